instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch sequencer on the producer side of the 6-bit instruction bus. It walks a program counter through a synchronous-read program memory and presents one instruction at a time to the instruction decoder, together with a valid strobe. Whenever no instruction is being executed, it drives the opcode-6 no-op pattern, which the decoder maps to all clock-enables low. It sits between the program memory and the decoder and provides run, single-step and PC-clear control.

## Interface
Parameters:
- PC_WIDTH, 6: program-counter and memory-address width; memory depth is 2^PC_WIDTH.
- INS_WIDTH, 6: instruction width; must match the decoder's `Ins` width.
- NOP_INS, 6'b011000: instruction driven when idle. Opcode 6 with register field 00.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Run  in  1  level; while high, instructions execute back-to-back.
- Step  in  1  one-cycle pulse; executes exactly one instruction when idle.
- PcClr  in  1  synchronous clear of the PC; aborts any instruction in flight.
- PMemRE  out  1  program-memory read enable.
- PMemAddr  out  PC_WIDTH  program-memory address; equals the PC.
- PMemData  in  INS_WIDTH  read data, valid the cycle after PMemRE.
- Ins  out  INS_WIDTH  instruction to the decoder; NOP_INS unless InsValid.
- InsValid  out  1  high for exactly the one cycle in which Ins is executed.
- PC  out  PC_WIDTH  current program counter.
- Busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, FETCH, LATCH, EXEC.
- IDLE:
  - PMemRE=0, Ins=NOP_INS, InsValid=0.
  - Goes to FETCH if Run=1, or if Step=1.
  - If Run=1 and Step=1 together, Run dominates; the Step pulse is not remembered.
- FETCH:
  - PMemRE=1, PMemAddr=PC.
  - Always goes to LATCH.
- LATCH:
  - PMemData is valid in this cycle.
  - At the end of the cycle: IR <= PMemData and PC <= PC+1 (modulo 2^PC_WIDTH).
  - Goes to EXEC.
- EXEC:
  - Ins=IR, InsValid=1.
  - Goes to FETCH if Run=1; otherwise goes to IDLE.
- Step pulses seen outside IDLE are ignored.
- Run deasserting in FETCH or LATCH: the current instruction completes through EXEC, then the FSM returns to IDLE.
- PC wrap-around: after address 2^PC_WIDTH-1 the PC becomes 0. There is no halt and no flag.
- PcClr=1 in any state, at the next edge:
  - PC <= 0, state <= IDLE, IR <= NOP_INS.
  - An in-flight instruction is dropped, and no InsValid is produced for it.
  - PcClr has priority over Run and Step in the same cycle.
- Ins is driven from a mux: IR in EXEC, NOP_INS in every other state. The decoder therefore never sees stale data outside EXEC.

## Timing
- Reset values:
  - state=IDLE, PC=0, IR=NOP_INS.
  - PMemRE=0, PMemAddr=0, Ins=NOP_INS, InsValid=0, Busy=0.
- Reset is asynchronous mid-operation: all registers return to their reset values immediately, and the instruction in flight is lost.
- Latency:
  - Run or Step sampled high in IDLE at edge N: FETCH in cycle N+1, LATCH in N+2, EXEC (InsValid=1) in N+3.
  - Sustained Run: one instruction every 3 cycles.
- PMemAddr and PMemRE are combinational from state and PC. There are no registered-output glitches at cycle start.
- PC visibly increments at the LATCH→EXEC edge. During EXEC, PC already points to the next instruction.

## Structure
- Shared package `uproc_pkg`:
  - opcode constants (including OPCODE_NOT and the opcode-6 no-op);
  - the NOP_INS constant;
  - the ALU code defines;
  - the fetch state enum `fetch_state_t`.
- One sub-module: `program_counter`. It holds the PC register with increment-enable, synchronous clear and async active-low reset.
- FSM, IR and output mux stay in `instruction_fetch`.

## Test plan
- Reset and idle: release nReset with Run=0 for 10 cycles -> Ins=6'b011000, InsValid=0, PMemRE=0, PC=0 throughout.
- Single step: memory[0]=6'b000001, pulse Step -> PMemRE=1 with addr 0 one cycle later; InsValid=1 with Ins=6'b000001 three cycles after the pulse; then IDLE with PC=1. A second Step pulse while Busy is ignored.
- Continuous run: load addresses 0..3, hold Run -> InsValid asserts every 3rd cycle with Ins = mem[0], mem[1], mem[2], mem[3] in order; PC=4 after the fourth EXEC.
- Wrap-around: PC_WIDTH=6, preset PC to 63 via a run sequence -> mem[63] executes, then PC=0 and mem[0] follows without a stall.
- Abort: assert PcClr during LATCH -> no InsValid for that instruction; next cycle shows PC=0 and IDLE; Ins=NOP_INS.
- Async reset mid-EXEC: drop nReset during InsValid=1 -> InsValid and Busy fall before the next clock edge; PC=0.

Source files
------------

// File: rtl/uproc_pkg.sv
// uproc_pkg: shared opcodes, ALU codes, idle instruction and fetch state encoding
package uproc_pkg;

    // Instruction layout: {opcode[3:0], reg[1:0]}
    localparam int OPCODE_WIDTH = 4;
    localparam int REG_WIDTH    = 2;

    localparam logic [OPCODE_WIDTH-1:0] OPCODE_LOAD  = 4'd0;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_STORE = 4'd1;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_ADD   = 4'd2;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_SUB   = 4'd3;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_AND   = 4'd4;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_OR    = 4'd5;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_NOP   = 4'd6;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_NOT   = 4'd7;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_NOT  = 3'd5;

    // Decoder maps opcode 6 to all clock-enables low, so this is a safe idle value
    localparam logic [5:0] NOP_INS = {OPCODE_NOP, 2'b00};

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_LATCH = 2'd2,
        FS_EXEC  = 2'd3
    } fetch_state_t;

    function automatic logic [5:0] make_ins(input logic [OPCODE_WIDTH-1:0] op,
                                            input logic [REG_WIDTH-1:0] rsel);
        return {op, rsel};
    endfunction

endpackage

// File: rtl/program_counter.sv
// program_counter: PC register with increment enable, synchronous clear and async reset
module program_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] pc_d, pc_q;

    // Clear beats increment; increment wraps naturally modulo 2^WIDTH
    always_comb pc_d = clr ? '0 : inc ? pc_q + 1'b1 : pc_q;

    // PC register
    always_ff @(posedge clk or negedge nReset)
        if (!nReset) pc_q <= '0;
        else         pc_q <= pc_d;

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: walks the PC through sync-read program memory and feeds the decoder
module instruction_fetch
    import uproc_pkg::*;
#(
    parameter int               PC_WIDTH  = 6,
    parameter int               INS_WIDTH = 6,
    parameter logic [INS_WIDTH-1:0] NOP_INS = uproc_pkg::NOP_INS
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 Run,
    input  logic                 Step,
    input  logic                 PcClr,
    output logic                 PMemRE,
    output logic [PC_WIDTH-1:0]  PMemAddr,
    input  logic [INS_WIDTH-1:0] PMemData,
    output logic [INS_WIDTH-1:0] Ins,
    output logic                 InsValid,
    output logic [PC_WIDTH-1:0]  PC,
    output logic                 Busy
);

    fetch_state_t         state_d, state_q;
    logic [INS_WIDTH-1:0] ir_d, ir_q;
    logic                 pc_inc;

    // Next state and IR load; PcClr overrides everything and drops the instruction in flight
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            FS_IDLE:  state_d = (Run || Step) ? FS_FETCH : FS_IDLE;
            FS_FETCH: state_d = FS_LATCH;
            FS_LATCH: begin
                state_d = FS_EXEC;
                ir_d    = PMemData;
            end
            FS_EXEC:  state_d = Run ? FS_FETCH : FS_IDLE;
            default:  state_d = FS_IDLE;
        endcase
        if (PcClr) begin
            state_d = FS_IDLE;
            ir_d    = NOP_INS;
        end
    end

    // State and instruction register
    always_ff @(posedge clk or negedge nReset)
        if (!nReset) begin
            state_q <= FS_IDLE;
            ir_q    <= NOP_INS;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end

    assign pc_inc = (state_q == FS_LATCH) && !PcClr;

    program_counter #(.WIDTH(PC_WIDTH)) u_pc (
        .clk   (clk),
        .nReset(nReset),
        .clr   (PcClr),
        .inc   (pc_inc),
        .pc    (PC)
    );

    // Outputs decode straight from state so an async reset clears them without waiting for an edge
    assign PMemRE   = state_q == FS_FETCH;
    assign PMemAddr = PC;
    assign InsValid = state_q == FS_EXEC;
    assign Ins      = InsValid ? ir_q : NOP_INS;
    assign Busy     = state_q != FS_IDLE;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for the fetch sequencer with a sync-read memory model
module tb_instruction_fetch;

    localparam logic [5:0] NOP = 6'b011000;

    logic       clk = 1'b0;
    logic       nReset;
    logic       Run, Step, PcClr;
    logic       PMemRE;
    logic [5:0] PMemAddr;
    logic [5:0] PMemData;
    logic [5:0] Ins;
    logic       InsValid;
    logic [5:0] PC;
    logic       Busy;

    typedef struct {
        logic [5:0] ins;
        logic [5:0] pc;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] mem [64];
    logic [5:0] model_pc;
    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_v = -1;
    bit         gap_chk = 0;

    instruction_fetch #(.PC_WIDTH(6), .INS_WIDTH(6), .NOP_INS(NOP)) dut (
        .clk     (clk),
        .nReset  (nReset),
        .Run     (Run),
        .Step    (Step),
        .PcClr   (PcClr),
        .PMemRE  (PMemRE),
        .PMemAddr(PMemAddr),
        .PMemData(PMemData),
        .Ins     (Ins),
        .InsValid(InsValid),
        .PC      (PC),
        .Busy    (Busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (PMemRE) PMemData <= mem[PMemAddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every executed instruction must match the head of the scoreboard
    always @(negedge clk) begin
        if (nReset && InsValid) begin
            if (sb.size() == 0) begin
                check("unexpected_insvalid", {26'd0, Ins}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ins", {26'd0, Ins}, {26'd0, e.ins});
                check("pc_in_exec", {26'd0, PC}, {26'd0, e.pc});
            end
            if (gap_chk && last_v >= 0) check("run_gap", cyc - last_v, 3);
            last_v = cyc;
        end
    end

    task automatic push(input logic [5:0] addr);
        exp_t e;
        e.ins = mem[addr];
        e.pc  = addr + 6'd1;
        sb.push_back(e);
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) begin
            push(model_pc);
            model_pc = model_pc + 6'd1;
        end
        gap_chk = 1;
        last_v  = -1;
        Run = 1'b1;
        repeat (3 * n - 2) @(posedge clk);
        #1 Run = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("run_busy_done", Busy, 0);
        check("run_pc_done", PC, model_pc);
        gap_chk = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 6'(i) ^ 6'h15;
        mem[0]  = 6'b000001;
        mem[1]  = 6'b000110;
        mem[2]  = 6'b101011;
        mem[3]  = 6'b111100;
        mem[63] = 6'b100111;
        PMemData = '0;
        model_pc = '0;
        nReset = 1'b0;
        Run = 1'b0; Step = 1'b0; PcClr = 1'b0;
        #2;
        check("reset_ins", Ins, NOP);
        check("reset_valid", InsValid, 0);
        check("reset_busy", Busy, 0);
        repeat (3) @(posedge clk);
        #1 nReset = 1'b1;

        // Idle with Run low
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ins", Ins, NOP);
            check("idle_valid", InsValid, 0);
            check("idle_re", PMemRE, 0);
            check("idle_pc", PC, 0);
        end
        @(posedge clk);
        #1;

        // Single step, with a second Step pulse while busy
        push(6'd0);
        model_pc = 6'd1;
        Step = 1'b1;
        @(posedge clk);
        #1 Step = 1'b0;
        @(negedge clk);
        check("step_re", PMemRE, 1);
        check("step_addr", PMemAddr, 0);
        check("step_busy", Busy, 1);
        @(posedge clk);
        #1 Step = 1'b1;
        @(negedge clk);
        check("step_latch_valid", InsValid, 0);
        @(posedge clk);
        #1 Step = 1'b0;
        @(negedge clk);
        check("step_exec_valid", InsValid, 1);
        @(posedge clk);
        @(negedge clk);
        check("step_idle_busy", Busy, 0);
        check("step_idle_pc", PC, 1);
        check("step_idle_valid", InsValid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("step_ignored_busy", Busy, 0);

        // Clear PC, and PcClr beats Run in the same cycle
        PcClr = 1'b1; Run = 1'b1;
        @(posedge clk);
        #1 PcClr = 1'b0; Run = 1'b0;
        model_pc = '0;
        @(negedge clk);
        check("clr_pri_busy", Busy, 0);
        check("clr_pc", PC, 0);
        @(posedge clk);
        #1;

        // Continuous run over 0..3, then up to 63 and across the wrap
        run_n(4);
        check("run4_pc", PC, 4);
        run_n(59);
        check("pre_wrap_pc", PC, 63);
        run_n(2);
        check("post_wrap_pc", PC, 1);

        // Abort during LATCH
        Step = 1'b1;
        @(posedge clk);
        #1 Step = 1'b0;
        @(posedge clk);
        #1 PcClr = 1'b1;
        @(posedge clk);
        #1 PcClr = 1'b0;
        model_pc = '0;
        @(negedge clk);
        check("abort_valid", InsValid, 0);
        check("abort_busy", Busy, 0);
        check("abort_pc", PC, 0);
        check("abort_ins", Ins, NOP);
        repeat (4) @(posedge clk);
        #1;

        // Async reset in the middle of EXEC
        push(6'd0);
        Step = 1'b1;
        @(posedge clk);
        #1 Step = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("areset_pre_valid", InsValid, 1);
        nReset = 1'b0;
        #1;
        check("areset_valid", InsValid, 0);
        check("areset_busy", Busy, 0);
        check("areset_pc", PC, 0);
        check("areset_ins", Ins, NOP);
        @(posedge clk);
        #1 nReset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
